// File: rtl/idex_pipe_reg_pkg.sv
// rtl/idex_pipe_reg_pkg.sv - shared widths, control-bus layout and field extraction for the ID/EX register
//
// Control bus layout (IDEX_CTRL_W = 12):
//   [0]     rs_read
//   [1]     rt_read
//   [2]     reg_write
//   [4:3]   reg_write_src
//   [9:5]   alu_op
//   [10]    mem_read
//   [11]    mem_write
// An all-zero control word is a bubble: it never reads, writes or touches memory.

`ifndef IDEX_PIPE_REG_DEFS
`define IDEX_PIPE_REG_DEFS

`define WORD_WIDTH   32
`define REG_ADDR_W   5
`define REG_ZERO     5'd0
`define ZERO_WORD    32'd0
`define IDEX_CTRL_W  12

`define IDEX_RS_READ_OFF    0
`define IDEX_RT_READ_OFF    1
`define IDEX_REG_WRITE_OFF  2
`define IDEX_REG_W_SRC_OFF  3
`define IDEX_REG_W_SRC_W    2
`define IDEX_ALU_OP_OFF     5
`define IDEX_ALU_OP_W       5
`define IDEX_MEM_READ_OFF   10
`define IDEX_MEM_WRITE_OFF  11

`define CTRL_RS_READ(c)   c[`IDEX_RS_READ_OFF]
`define CTRL_RT_READ(c)   c[`IDEX_RT_READ_OFF]
`define CTRL_REG_WRITE(c) c[`IDEX_REG_WRITE_OFF]
`define CTRL_REG_W_SRC(c) c[`IDEX_REG_W_SRC_OFF +: `IDEX_REG_W_SRC_W]
`define CTRL_ALU_OP(c)    c[`IDEX_ALU_OP_OFF +: `IDEX_ALU_OP_W]
`define CTRL_MEM_READ(c)  c[`IDEX_MEM_READ_OFF]
`define CTRL_MEM_WRITE(c) c[`IDEX_MEM_WRITE_OFF]

`endif

package idex_pipe_reg_pkg;

  localparam int WORD_W     = `WORD_WIDTH;
  localparam int REG_ADDR_W = `REG_ADDR_W;
  localparam int CTRL_W     = `IDEX_CTRL_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = `REG_ZERO;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // A WB write refreshes a held operand only if it targets a real register
  // and matches the operand's index.
  function automatic logic wb_hits(input logic                  wb_we,
                                   input logic [REG_ADDR_W-1:0] wb_addr,
                                   input logic [REG_ADDR_W-1:0] op_addr);
    return wb_we && (wb_addr != REG_ZERO) && (wb_addr == op_addr);
  endfunction

endpackage

// File: rtl/idex_pipe_reg_if.sv
// rtl/idex_pipe_reg_if.sv - ID/EX bus: ID inputs, hazard/flush controls, WB snoop port and EX outputs
//
// Modports:
//   master - the driving side (ID stage, hazard unit, WB, EX consumer)
//   slave  - the ID/EX pipeline register
// Optional: IDEX_PERF_CNT_EN adds perf_hold_cycles / perf_flushes.

interface idex_pipe_reg_if
  import idex_pipe_reg_pkg::*;
#(
  parameter int W      = `WORD_WIDTH,
  parameter int CTRL_W = `IDEX_CTRL_W
);

  logic                  id_valid;
  logic [W-1:0]          id_pc;
  logic [W-1:0]          id_imm;
  logic [W-1:0]          id_rs_val;
  logic [W-1:0]          id_rt_val;
  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic [REG_ADDR_W-1:0] id_rt_addr;
  logic [REG_ADDR_W-1:0] id_wr_addr;
  logic [CTRL_W-1:0]     id_ctrl;

  logic                  flush;
  logic                  mem_ex_hazard;
  logic                  mem_stall;

  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_reg_write_addr;
  logic [W-1:0]          wb_reg_write_data;

  logic                  ex_valid;
  logic [W-1:0]          ex_pc;
  logic [W-1:0]          ex_imm;
  logic [W-1:0]          ex_rs_val;
  logic [W-1:0]          ex_rt_val;
  logic [REG_ADDR_W-1:0] ex_rs_addr;
  logic [REG_ADDR_W-1:0] ex_rt_addr;
  logic [REG_ADDR_W-1:0] ex_wr_addr;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic                  id_stall;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0]           perf_hold_cycles;
  logic [31:0]           perf_flushes;
`endif

  modport master (
`ifdef IDEX_PERF_CNT_EN
    input  perf_hold_cycles, perf_flushes,
`endif
    output id_valid, id_pc, id_imm, id_rs_val, id_rt_val,
           id_rs_addr, id_rt_addr, id_wr_addr, id_ctrl,
           flush, mem_ex_hazard, mem_stall,
           wb_reg_write, wb_reg_write_addr, wb_reg_write_data,
    input  ex_valid, ex_pc, ex_imm, ex_rs_val, ex_rt_val,
           ex_rs_addr, ex_rt_addr, ex_wr_addr, ex_ctrl, id_stall
  );

  modport slave (
`ifdef IDEX_PERF_CNT_EN
    output perf_hold_cycles, perf_flushes,
`endif
    input  id_valid, id_pc, id_imm, id_rs_val, id_rt_val,
           id_rs_addr, id_rt_addr, id_wr_addr, id_ctrl,
           flush, mem_ex_hazard, mem_stall,
           wb_reg_write, wb_reg_write_addr, wb_reg_write_data,
    output ex_valid, ex_pc, ex_imm, ex_rs_val, ex_rt_val,
           ex_rs_addr, ex_rt_addr, ex_wr_addr, ex_ctrl, id_stall
  );

endinterface

// File: rtl/idex_operand_refresh.sv
// rtl/idex_operand_refresh.sv - next value of one held operand given the WB write port
//
// Ports:
//   held_val   in  W           operand value currently latched in ID/EX
//   held_addr  in  REG_ADDR_W  register index of that operand
//   wb_we      in  1           WB writes the regfile this cycle
//   wb_addr    in  REG_ADDR_W  WB destination index
//   wb_data    in  W           WB write data
//   next_val   out W           value the operand should hold next cycle

module idex_operand_refresh
  import idex_pipe_reg_pkg::*;
#(
  parameter int W = `WORD_WIDTH
) (
  input  logic [W-1:0]          held_val,
  input  logic [REG_ADDR_W-1:0] held_addr,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [W-1:0]          wb_data,
  output logic [W-1:0]          next_val
);

  always_comb begin
    next_val = held_val;
    if (wb_hits(wb_we, wb_addr, held_addr)) begin
      next_val = wb_data;
    end
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// rtl/idex_pipe_reg.sv - ID/EX pipeline register with hold, flush-to-bubble and WB snoop of held operands
//
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset; register becomes a bubble, all outputs 0
//   bus  idex_pipe_reg_if.slave: id_* in, flush/mem_ex_hazard/mem_stall in,
//        wb_* in, ex_* out (registered), id_stall out (combinational)
// Optional: IDEX_PERF_CNT_EN adds perf_hold_cycles and perf_flushes counters.

module idex_pipe_reg
  import idex_pipe_reg_pkg::*;
#(
  parameter int W      = `WORD_WIDTH,
  parameter int CTRL_W = `IDEX_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  idex_pipe_reg_if.slave    bus
);

  logic                  ex_valid_q;
  logic [W-1:0]          ex_pc_q;
  logic [W-1:0]          ex_imm_q;
  logic [W-1:0]          ex_rs_val_q;
  logic [W-1:0]          ex_rt_val_q;
  logic [REG_ADDR_W-1:0] ex_rs_addr_q;
  logic [REG_ADDR_W-1:0] ex_rt_addr_q;
  logic [REG_ADDR_W-1:0] ex_wr_addr_q;
  logic [CTRL_W-1:0]     ex_ctrl_q;

  logic                  hold;
  logic [W-1:0]          rs_refreshed;
  logic [W-1:0]          rt_refreshed;

  // Only a real instruction can be held; a bubble always advances.
  // Flush overrides hold so ID is released in the same cycle.
  assign hold = ex_valid_q & (bus.mem_ex_hazard | bus.mem_stall) & ~bus.flush;

  idex_operand_refresh #(.W(W)) u_rs_refresh (
    .held_val  (ex_rs_val_q),
    .held_addr (ex_rs_addr_q),
    .wb_we     (bus.wb_reg_write),
    .wb_addr   (bus.wb_reg_write_addr),
    .wb_data   (bus.wb_reg_write_data),
    .next_val  (rs_refreshed)
  );

  idex_operand_refresh #(.W(W)) u_rt_refresh (
    .held_val  (ex_rt_val_q),
    .held_addr (ex_rt_addr_q),
    .wb_we     (bus.wb_reg_write),
    .wb_addr   (bus.wb_reg_write_addr),
    .wb_data   (bus.wb_reg_write_data),
    .next_val  (rt_refreshed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_rs_val_q  <= '0;
      ex_rt_val_q  <= '0;
      ex_rs_addr_q <= '0;
      ex_rt_addr_q <= '0;
      ex_wr_addr_q <= '0;
      ex_ctrl_q    <= '0;
    end else if (bus.flush) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_rs_val_q  <= '0;
      ex_rt_val_q  <= '0;
      ex_rs_addr_q <= '0;
      ex_rt_addr_q <= '0;
      ex_wr_addr_q <= '0;
      ex_ctrl_q    <= '0;
    end else if (hold) begin
      // Everything else keeps its value; operands track WB so the held
      // instruction sees the result of a writer that retires meanwhile.
      ex_rs_val_q  <= rs_refreshed;
      ex_rt_val_q  <= rt_refreshed;
    end else if (bus.id_valid) begin
      // No refresh here: the regfile already bypasses a same-cycle WB.
      ex_valid_q   <= 1'b1;
      ex_pc_q      <= bus.id_pc;
      ex_imm_q     <= bus.id_imm;
      ex_rs_val_q  <= bus.id_rs_val;
      ex_rt_val_q  <= bus.id_rt_val;
      ex_rs_addr_q <= bus.id_rs_addr;
      ex_rt_addr_q <= bus.id_rt_addr;
      ex_wr_addr_q <= bus.id_wr_addr;
      ex_ctrl_q    <= bus.id_ctrl;
    end else begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_rs_val_q  <= '0;
      ex_rt_val_q  <= '0;
      ex_rs_addr_q <= '0;
      ex_rt_addr_q <= '0;
      ex_wr_addr_q <= '0;
      ex_ctrl_q    <= CTRL_BUBBLE;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_rs_val  = ex_rs_val_q;
  assign bus.ex_rt_val  = ex_rt_val_q;
  assign bus.ex_rs_addr = ex_rs_addr_q;
  assign bus.ex_rt_addr = ex_rt_addr_q;
  assign bus.ex_wr_addr = ex_wr_addr_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.id_stall   = hold;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] perf_hold_q;
  logic [31:0] perf_flush_q;

  // Only flushes that actually kill an instruction are counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hold_q  <= '0;
      perf_flush_q <= '0;
    end else begin
      if (hold) begin
        perf_hold_q <= perf_hold_q + 32'd1;
      end
      if (bus.flush && ex_valid_q) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign bus.perf_hold_cycles = perf_hold_q;
  assign bus.perf_flushes     = perf_flush_q;
`endif

endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb/tb_idex_pipe_reg.sv - directed self-checking bench for idex_pipe_reg

`timescale 1ns/1ps

module tb_idex_pipe_reg;
  import idex_pipe_reg_pkg::*;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  idex_pipe_reg_if bus ();

  idex_pipe_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    rst                   = 1'b1;
    bus.id_valid          = 1'b0;
    bus.id_pc             = '0;
    bus.id_imm            = '0;
    bus.id_rs_val         = '0;
    bus.id_rt_val         = '0;
    bus.id_rs_addr        = '0;
    bus.id_rt_addr        = '0;
    bus.id_wr_addr        = '0;
    bus.id_ctrl           = '0;
    bus.flush             = 1'b0;
    bus.mem_ex_hazard     = 1'b0;
    bus.mem_stall         = 1'b0;
    bus.wb_reg_write      = 1'b0;
    bus.wb_reg_write_addr = '0;
    bus.wb_reg_write_data = '0;

    cycle();
    cycle();
    check_val("rst_valid", 64'(bus.ex_valid), 64'd0);
    check_val("rst_pc",    64'(bus.ex_pc),    64'd0);
    check_val("rst_ctrl",  64'(bus.ex_ctrl),  64'd0);
    check_val("rst_stall", 64'(bus.id_stall), 64'd0);
    rst = 1'b0;

    // Advance a reg_write instruction.
    bus.id_valid   = 1'b1;
    bus.id_pc      = 32'h100;
    bus.id_imm     = 32'h44;
    bus.id_rs_val  = 32'hA;
    bus.id_rt_val  = 32'hB;
    bus.id_rs_addr = 5'd5;
    bus.id_rt_addr = 5'd5;
    bus.id_wr_addr = 5'd7;
    bus.id_ctrl    = 12'h004;
    cycle();
    check_val("adv_pc",     64'(bus.ex_pc),     64'h100);
    check_val("adv_rs_val", 64'(bus.ex_rs_val), 64'hA);
    check_val("adv_rt_val", 64'(bus.ex_rt_val), 64'hB);
    check_val("adv_imm",    64'(bus.ex_imm),    64'h44);
    check_val("adv_wr",     64'(bus.ex_wr_addr), 64'd7);
    check_val("adv_valid",  64'(bus.ex_valid),  64'd1);
    check_val("adv_regwr",  64'(`CTRL_REG_WRITE(bus.ex_ctrl)), 64'd1);
    check_val("adv_stall",  64'(bus.id_stall),  64'd0);

    // Load-use hold for one cycle.
    bus.id_pc         = 32'h104;
    bus.mem_ex_hazard = 1'b1;
    #1;
    check_val("lu_stall", 64'(bus.id_stall), 64'd1);
    cycle();
    check_val("lu_pc_held", 64'(bus.ex_pc), 64'h100);
    bus.mem_ex_hazard = 1'b0;
    #1;
    check_val("lu_release_stall", 64'(bus.id_stall), 64'd0);
    cycle();
    check_val("lu_pc_adv", 64'(bus.ex_pc), 64'h104);

    // Refresh during a downstream stall: WB to r5 updates both operands.
    bus.id_pc             = 32'h108;
    bus.mem_stall         = 1'b1;
    bus.wb_reg_write      = 1'b1;
    bus.wb_reg_write_addr = 5'd5;
    bus.wb_reg_write_data = 32'hDEAD;
    cycle();
    check_val("ref_rs",   64'(bus.ex_rs_val), 64'hDEAD);
    check_val("ref_rt",   64'(bus.ex_rt_val), 64'hDEAD);
    check_val("ref_pc",   64'(bus.ex_pc),     64'h104);
    check_val("ref_stall", 64'(bus.id_stall), 64'd1);
    // Write to r0 never refreshes.
    bus.wb_reg_write_addr = 5'd0;
    bus.wb_reg_write_data = 32'hBEEF;
    cycle();
    check_val("ref0_rs", 64'(bus.ex_rs_val), 64'hDEAD);
    check_val("ref0_rt", 64'(bus.ex_rt_val), 64'hDEAD);
    // Non-matching index does not refresh either.
    bus.wb_reg_write_addr = 5'd6;
    bus.wb_reg_write_data = 32'h1234;
    cycle();
    check_val("ref6_rs", 64'(bus.ex_rs_val), 64'hDEAD);

    // Flush beats hold.
    bus.wb_reg_write  = 1'b0;
    bus.mem_ex_hazard = 1'b1;
    bus.flush         = 1'b1;
    #1;
    check_val("fl_stall", 64'(bus.id_stall), 64'd0);
    cycle();
    check_val("fl_valid", 64'(bus.ex_valid), 64'd0);
    check_val("fl_ctrl",  64'(bus.ex_ctrl),  64'd0);
    check_val("fl_pc",    64'(bus.ex_pc),    64'd0);
    bus.flush = 1'b0;

    // Bubble passthrough with hazard/stall still asserted.
    bus.id_valid = 1'b0;
    bus.id_ctrl  = 12'h800;
    #1;
    check_val("bub_stall0", 64'(bus.id_stall), 64'd0);
    cycle();
    check_val("bub_valid", 64'(bus.ex_valid), 64'd0);
    check_val("bub_ctrl",  64'(bus.ex_ctrl),  64'd0);
    check_val("bub_stall", 64'(bus.id_stall), 64'd0);

    // With ex_valid=0 the hazard is ignored and a real instruction advances.
    bus.id_valid = 1'b1;
    bus.id_pc    = 32'h200;
    bus.id_ctrl  = 12'h3FF;
    cycle();
    check_val("adv2_valid", 64'(bus.ex_valid), 64'd1);
    check_val("adv2_pc",    64'(bus.ex_pc),    64'h200);
    check_val("adv2_ctrl",  64'(bus.ex_ctrl),  64'h3FF);
    check_val("adv2_stall", 64'(bus.id_stall), 64'd1);

    // Reset mid-run clears outputs before the next clock edge.
    rst = 1'b1;
    #1;
    check_val("mrst_valid", 64'(bus.ex_valid), 64'd0);
    check_val("mrst_ctrl",  64'(bus.ex_ctrl),  64'd0);
    check_val("mrst_pc",    64'(bus.ex_pc),    64'd0);
    check_val("mrst_rs",    64'(bus.ex_rs_val), 64'd0);
    check_val("mrst_stall", 64'(bus.id_stall), 64'd0);
    cycle();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
